// File: rtl/ifmap_stream_loader_pkg.sv
// Shared types and constants for the ifmap stream loader: pixel type, read FSM
// states, ping-pong bank bookkeeping widths and an index-width helper.
package ifmap_stream_loader_pkg;

    localparam int PIXEL_WIDTH = 8;

    // Two banks: one is loaded from the stream while the other feeds conv.
    localparam int BANK_COUNT = 2;
    localparam int BANK_IDX_W = $clog2(BANK_COUNT);
    // full_cnt must be able to hold every value 0..BANK_COUNT.
    localparam int FULL_CNT_W = $clog2(BANK_COUNT + 1);

    typedef logic signed [PIXEL_WIDTH-1:0] pixel_t;
    typedef logic [BANK_IDX_W-1:0]         bank_idx_t;
    typedef logic [FULL_CNT_W-1:0]         full_cnt_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN
    } ld_rd_state_t;

    // Width of a row/column index. A dimension of 1 still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ifmap_stream_loader_if.sv
// Valid/ready pixel stream feeding the loader. The producer drives the
// master side; the loader sits on the slave side and returns s_ready.
interface ifmap_stream_loader_if #(
    parameter int DATA_WIDTH = 8
);

    logic                         s_valid;
    logic                         s_ready;
    logic signed [DATA_WIDTH-1:0] s_data;
    logic                         s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/ifmap_stream_loader_bank.sv
// One frame bank of the ping-pong buffer: a HEIGHT x WIDTH pixel array with a
// single synchronous write port and the whole array visible in parallel.
// Contents are deliberately not reset; a bank is only read after a full load.
module ifmap_stream_loader_bank
    import ifmap_stream_loader_pkg::*;
#(
    parameter int HEIGHT     = 128,
    parameter int WIDTH      = 128,
    parameter int DATA_WIDTH = PIXEL_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 we,
    input  logic [idx_width(HEIGHT)-1:0]         row,
    input  logic [idx_width(WIDTH)-1:0]          col,
    input  logic signed [DATA_WIDTH-1:0]         data,
    output logic signed [DATA_WIDTH-1:0]         mem [HEIGHT][WIDTH]
);

    // Store one pixel at (row, col) whenever the write side targets this bank.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[row][col] <= data;
        end
    end

endmodule

// File: rtl/ifmap_stream_loader.sv
// Streaming front end of the conv -> maxpool chain. Raster-order pixels are
// written into a two-bank ping-pong buffer; a completed bank is presented as the
// parallel ifmap with en held high until the chain reports done. The next frame
// loads into the other bank while the current one is being processed.
module ifmap_stream_loader
    import ifmap_stream_loader_pkg::*;
#(
    parameter int IFMAP_HEIGHT = 128,
    parameter int IFMAP_WIDTH  = 128,
    parameter int DATA_WIDTH   = PIXEL_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    ifmap_stream_loader_if.slave         stream,
    output logic signed [DATA_WIDTH-1:0] ifmap [IFMAP_HEIGHT][IFMAP_WIDTH],
    output logic                         en,
    input  logic                         done_in,
    output logic                         frame_err
);

    localparam int ROW_W = idx_width(IFMAP_HEIGHT);
    localparam int COL_W = idx_width(IFMAP_WIDTH);

    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IFMAP_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IFMAP_WIDTH - 1);
    localparam full_cnt_t        FULL_LIMIT = full_cnt_t'(BANK_COUNT);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    bank_idx_t        wr_bank;
    bank_idx_t        rd_bank;
    full_cnt_t        full_cnt;
    ld_rd_state_t     rd_state;

    logic xfer;
    logic last_pix;
    logic frame_done;
    logic bank_free;
    logic we0;
    logic we1;

    logic signed [DATA_WIDTH-1:0] bank0_q [IFMAP_HEIGHT][IFMAP_WIDTH];
    logic signed [DATA_WIDTH-1:0] bank1_q [IFMAP_HEIGHT][IFMAP_WIDTH];

    // The loader can take a pixel as long as at least one bank is not holding
    // an unretired frame; full_cnt therefore never exceeds BANK_COUNT.
    assign stream.s_ready = (full_cnt < FULL_LIMIT);

    assign xfer       = stream.s_valid & stream.s_ready;
    assign last_pix   = (row == ROW_LAST) && (col == COL_LAST);
    assign frame_done = xfer & last_pix;
    assign bank_free  = (rd_state == RD_RUN) & done_in;

    assign we0 = xfer & (wr_bank == bank_idx_t'(0));
    assign we1 = xfer & (wr_bank == bank_idx_t'(1));

    ifmap_stream_loader_bank #(
        .HEIGHT     (IFMAP_HEIGHT),
        .WIDTH      (IFMAP_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank0 (
        .clk  (clk),
        .we   (we0),
        .row  (row),
        .col  (col),
        .data (stream.s_data),
        .mem  (bank0_q)
    );

    ifmap_stream_loader_bank #(
        .HEIGHT     (IFMAP_HEIGHT),
        .WIDTH      (IFMAP_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank1 (
        .clk  (clk),
        .we   (we1),
        .row  (row),
        .col  (col),
        .data (stream.s_data),
        .mem  (bank1_q)
    );

    // Raster write pointer, write-bank toggle and framing-error pulse. An early
    // s_last throws the partial frame away and restarts the same bank; a final
    // pixel without s_last still completes the frame but is flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row       <= '0;
            col       <= '0;
            wr_bank   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= xfer & (stream.s_last ^ last_pix);
            if (xfer) begin
                if (last_pix) begin
                    row     <= '0;
                    col     <= '0;
                    wr_bank <= wr_bank ^ bank_idx_t'(1);
                end else if (stream.s_last) begin
                    row <= '0;
                    col <= '0;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // Count of banks holding complete, unretired frames, and the read pointer.
    // A completion and a retirement on the same edge cancel in the count while
    // both pointers still advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_cnt <= '0;
            rd_bank  <= '0;
        end else begin
            if (frame_done && !bank_free) begin
                full_cnt <= full_cnt + full_cnt_t'(1);
            end else if (!frame_done && bank_free) begin
                full_cnt <= full_cnt - full_cnt_t'(1);
            end
            if (bank_free) begin
                rd_bank <= rd_bank ^ bank_idx_t'(1);
            end
        end
    end

    // Read FSM: present a full bank with en high until done, then wait for done
    // to fall so a done level left over from this frame cannot retire the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state <= RD_IDLE;
            en       <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (full_cnt != '0) begin
                        rd_state <= RD_RUN;
                        en       <= 1'b1;
                    end
                end
                RD_RUN: begin
                    if (done_in) begin
                        rd_state <= RD_DRAIN;
                        en       <= 1'b0;
                    end
                end
                RD_DRAIN: begin
                    if (!done_in) begin
                        rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    rd_state <= RD_IDLE;
                    en       <= 1'b0;
                end
            endcase
        end
    end

    // Present the read bank as the parallel ifmap; rd_bank only moves when a
    // frame is retired, so the image is steady for the whole run.
    always_comb begin
        for (int r = 0; r < IFMAP_HEIGHT; r++) begin
            for (int c = 0; c < IFMAP_WIDTH; c++) begin
                ifmap[r][c] = (rd_bank == bank_idx_t'(1)) ? bank1_q[r][c] : bank0_q[r][c];
            end
        end
    end

endmodule

// File: tb/tb_ifmap_stream_loader.sv
// Directed testbench for ifmap_stream_loader using a small non-square frame.
// Frames are generated from a simple pattern (a + b*row + col, wrapped to the
// pixel width) so expected ifmap contents come from the bench itself.
module tb_ifmap_stream_loader;

    localparam int H  = 6;
    localparam int W  = 10;
    localparam int DW = 8;
    localparam int NPIX = H * W;

    logic clk;
    logic reset;
    logic done_in;
    logic en;
    logic frame_err;
    logic signed [DW-1:0] ifmap [H][W];

    int checks;
    int passes;
    int err_pulses;
    int err_wide;
    logic err_prev;

    ifmap_stream_loader_if #(.DATA_WIDTH(DW)) s_if ();

    ifmap_stream_loader #(
        .IFMAP_HEIGHT (H),
        .IFMAP_WIDTH  (W),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stream    (s_if.slave),
        .ifmap     (ifmap),
        .en        (en),
        .done_in   (done_in),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_err pulses and flag any pulse wider than one cycle.
    initial begin
        err_pulses = 0;
        err_wide   = 0;
        err_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) begin
                if (err_prev === 1'b1) err_wide++;
                else err_pulses++;
            end
            err_prev = frame_err;
        end
    end

    function automatic logic signed [DW-1:0] pix(input int a, input int b, input int i, input int j);
        return DW'(a + b * i + j);
    endfunction

    function automatic int frame_mismatches(input int a, input int b);
        int bad;
        bad = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (ifmap[r][c] !== pix(a, b, r, c)) bad++;
        return bad;
    endfunction

    // Stream n_pix pixels of pattern (a,b); s_last on index last_at (-1: never).
    // Starts and ends on a negedge; ready waits are bounded.
    task automatic send_frame(input int a, input int b, input int n_pix, input int last_at);
        int wait_n;
        for (int k = 0; k < n_pix; k++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = pix(a, b, k / W, k % W);
            s_if.s_last  = (k == last_at);
            wait_n = 0;
            while (s_if.s_ready !== 1'b1 && wait_n < 200) begin
                @(negedge clk);
                wait_n++;
            end
            if (s_if.s_ready !== 1'b1) begin
                checks++;
                $display("[TB] FAIL ready_timeout: pixel %0d not accepted, s_ready=%b required 1", k, s_if.s_ready);
                break;
            end
            @(negedge clk);
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    // Retire the presented frame with a one-cycle done pulse and let the FSM drain.
    task automatic retire_frame();
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        done_in      = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        s_if.s_data  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (en !== 1'b0) $display("[TB] FAIL reset_en: got %b required 0", en);
        else passes++;
        checks++;
        if (frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err: got %b required 0", frame_err);
        else passes++;
        checks++;
        if (s_if.s_ready !== 1'b1) $display("[TB] FAIL reset_s_ready: got %b required 1", s_if.s_ready);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int base;
        int bad;
        base = err_pulses;
        send_frame(0, 1, NPIX, NPIX - 1);
        checks++;
        if (en !== 1'b0) $display("[TB] FAIL single_en_early: got %b required 0", en);
        else passes++;
        @(negedge clk);
        checks++;
        if (en !== 1'b1) $display("[TB] FAIL single_en: got %b required 1", en);
        else passes++;
        checks++;
        if (ifmap[3][5] !== 8) $display("[TB] FAIL single_pixel_3_5: got %0d required 8", ifmap[3][5]);
        else passes++;
        bad = frame_mismatches(0, 1);
        checks++;
        if (bad !== 0) $display("[TB] FAIL single_frame: %0d pixels wrong, required 0", bad);
        else passes++;
        checks++;
        if (err_pulses - base !== 0) $display("[TB] FAIL single_no_err: got %0d pulses required 0", err_pulses - base);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int bad;
        retire_frame();
        send_frame(17, 13, NPIX, NPIX - 1);
        send_frame(200, 7, NPIX, NPIX - 1);
        checks++;
        if (s_if.s_ready !== 1'b0) $display("[TB] FAIL b2b_ready_full: got %b required 0", s_if.s_ready);
        else passes++;
        checks++;
        if (en !== 1'b1) $display("[TB] FAIL b2b_en_first: got %b required 1", en);
        else passes++;
        bad = frame_mismatches(17, 13);
        checks++;
        if (bad !== 0) $display("[TB] FAIL b2b_frame_a: %0d pixels wrong, required 0", bad);
        else passes++;
        done_in = 1'b1;
        @(negedge clk);
        checks++;
        if (en !== 1'b0) $display("[TB] FAIL b2b_en_drop: got %b required 0", en);
        else passes++;
        checks++;
        if (s_if.s_ready !== 1'b1) $display("[TB] FAIL b2b_ready_freed: got %b required 1", s_if.s_ready);
        else passes++;
        done_in = 1'b0;
        @(negedge clk);
        checks++;
        if (en !== 1'b0) $display("[TB] FAIL b2b_en_drain: got %b required 0", en);
        else passes++;
        @(negedge clk);
        bad = frame_mismatches(200, 7);
        checks++;
        if (en !== 1'b1 || bad !== 0)
            $display("[TB] FAIL b2b_frame_b: en=%b wrong_pixels=%0d required en=1 wrong_pixels=0", en, bad);
        else passes++;
        retire_frame();
    endtask

    task automatic test_early_last();
        int base;
        int bad;
        base = err_pulses;
        send_frame(40, 3, 21, 20);
        repeat (3) @(negedge clk);
        checks++;
        if (err_pulses - base !== 1) $display("[TB] FAIL early_err_pulse: got %0d pulses required 1", err_pulses - base);
        else passes++;
        checks++;
        if (en !== 1'b0) $display("[TB] FAIL early_en: got %b required 0", en);
        else passes++;
        send_frame(90, 11, NPIX, NPIX - 1);
        @(negedge clk);
        checks++;
        if (en !== 1'b1) $display("[TB] FAIL early_next_en: got %b required 1", en);
        else passes++;
        bad = frame_mismatches(90, 11);
        checks++;
        if (bad !== 0) $display("[TB] FAIL early_next_frame: %0d pixels wrong, required 0", bad);
        else passes++;
        checks++;
        if (err_pulses - base !== 1) $display("[TB] FAIL early_next_no_err: got %0d pulses required 1", err_pulses - base);
        else passes++;
        retire_frame();
    endtask

    task automatic test_no_last();
        int base;
        int bad;
        base = err_pulses;
        send_frame(120, 5, NPIX, -1);
        @(negedge clk);
        checks++;
        if (en !== 1'b1) $display("[TB] FAIL nolast_en: got %b required 1", en);
        else passes++;
        bad = frame_mismatches(120, 5);
        checks++;
        if (bad !== 0) $display("[TB] FAIL nolast_frame: %0d pixels wrong, required 0", bad);
        else passes++;
        checks++;
        if (err_pulses - base !== 1) $display("[TB] FAIL nolast_err_pulse: got %0d pulses required 1", err_pulses - base);
        else passes++;
        retire_frame();
    endtask

    task automatic test_done_held();
        int hi;
        int bad;
        send_frame(7, 9, NPIX, NPIX - 1);
        @(negedge clk);
        checks++;
        if (en !== 1'b1) $display("[TB] FAIL held_en_first: got %b required 1", en);
        else passes++;
        done_in = 1'b1;
        @(negedge clk);
        checks++;
        if (en !== 1'b0) $display("[TB] FAIL held_en_retire: got %b required 0", en);
        else passes++;
        send_frame(222, 17, NPIX, NPIX - 1);
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (en === 1'b1) hi++;
        end
        checks++;
        if (hi !== 0) $display("[TB] FAIL held_en_stays_low: en high for %0d cycles, required 0", hi);
        else passes++;
        done_in = 1'b0;
        @(negedge clk);
        checks++;
        if (en !== 1'b0) $display("[TB] FAIL held_en_drain: got %b required 0", en);
        else passes++;
        @(negedge clk);
        checks++;
        if (en !== 1'b1) $display("[TB] FAIL held_en_second: got %b required 1", en);
        else passes++;
        bad = frame_mismatches(222, 17);
        checks++;
        if (bad !== 0) $display("[TB] FAIL held_frame_second: %0d pixels wrong, required 0", bad);
        else passes++;
        retire_frame();
    endtask

    task automatic test_reset_mid();
        int base;
        int bad;
        send_frame(60, 2, NPIX, NPIX - 1);
        @(negedge clk);
        checks++;
        if (en !== 1'b1) $display("[TB] FAIL rstmid_en_before: got %b required 1", en);
        else passes++;
        send_frame(33, 4, 25, -1);
        reset = 1'b0;
        #1;
        checks++;
        if (en !== 1'b0) $display("[TB] FAIL rstmid_en_async: got %b required 0", en);
        else passes++;
        checks++;
        if (frame_err !== 1'b0) $display("[TB] FAIL rstmid_frame_err: got %b required 0", frame_err);
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (s_if.s_ready !== 1'b1) $display("[TB] FAIL rstmid_ready: got %b required 1", s_if.s_ready);
        else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (en !== 1'b0) $display("[TB] FAIL rstmid_no_stale_frame: got %b required 0", en);
        else passes++;
        base = err_pulses;
        send_frame(150, 19, NPIX, NPIX - 1);
        checks++;
        if (en !== 1'b0) $display("[TB] FAIL rstmid_en_early: got %b required 0", en);
        else passes++;
        @(negedge clk);
        bad = frame_mismatches(150, 19);
        checks++;
        if (en !== 1'b1 || bad !== 0)
            $display("[TB] FAIL rstmid_new_frame: en=%b wrong_pixels=%0d required en=1 wrong_pixels=0", en, bad);
        else passes++;
        checks++;
        if (err_pulses - base !== 0) $display("[TB] FAIL rstmid_no_err: got %0d pulses required 0", err_pulses - base);
        else passes++;
        retire_frame();
    endtask

    task automatic test_err_width();
        checks++;
        if (err_wide !== 0) $display("[TB] FAIL err_width: %0d multi-cycle frame_err pulses, required 0", err_wide);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        $display("[TB] starting ifmap_stream_loader directed tests");
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_early_last();
        test_no_last();
        test_done_held();
        test_reset_mid();
        test_err_width();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
